// File: rtl/ball_trajectory_pkg.sv
// Shared constants and state encoding for the ball trajectory and renderer.
// Position/velocity are fixed point with BT_FRAC fractional bits.
package ball_trajectory_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int BT_FRAC  = 4;
    localparam int BALL_R   = 4;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FLIGHT = 2'd1;
    localparam logic [1:0] ST_LANDED = 2'd2;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        FLIGHT = ST_FLIGHT,
        LANDED = ST_LANDED
    } ball_state_t;

endpackage

// File: rtl/ball_step.sv
// One-frame integration step: wall bounce, ceiling clamp, floor landing and hoop-crossing detect.
module ball_step
    import ball_trajectory_pkg::*;
#(
    parameter int FRAC     = BT_FRAC,
    parameter int GRAVITY  = 4,
    parameter int X_MIN    = 4,
    parameter int X_MAX    = 635,
    parameter int FLOOR_Y  = 475,
    parameter int HOOP_X_L = 500,
    parameter int HOOP_X_R = 530,
    parameter int HOOP_Y   = 200
)(
    input  logic [9+FRAC:0]   pos_x,
    input  logic [9+FRAC:0]   pos_y,
    input  logic signed [7:0] vx,
    input  logic signed [7:0] vy,
    output logic [9+FRAC:0]   next_x,
    output logic [9+FRAC:0]   next_y,
    output logic signed [7:0] next_vx,
    output logic signed [7:0] next_vy,
    output logic              wall_hit,
    output logic              floor_hit,
    output logic              hoop_cross
);

    localparam int PW = 10 + FRAC;
    localparam logic [9:0] XMIN_I   = 10'(X_MIN);
    localparam logic [9:0] XMAX_I   = 10'(X_MAX);
    localparam logic [9:0] FLOOR_I  = 10'(FLOOR_Y);
    localparam logic [9:0] HOOPL_I  = 10'(HOOP_X_L);
    localparam logic [9:0] HOOPR_I  = 10'(HOOP_X_R);
    localparam logic [9:0] HOOPY_I  = 10'(HOOP_Y);

    // One extra sign bit so moving past 0 shows up as a negative sum.
    logic signed [PW:0] sum_x;
    logic signed [PW:0] sum_y;
    logic [9:0]         int_x;
    logic [9:0]         int_y;
    logic [9:0]         int_y_old;
    logic signed [8:0]  vy_grav;

    always_comb begin
        sum_x     = $signed({1'b0, pos_x}) + $signed({{(PW-7){vx[7]}}, vx});
        sum_y     = $signed({1'b0, pos_y}) + $signed({{(PW-7){vy[7]}}, vy});
        int_x     = sum_x[PW-1:FRAC];
        int_y     = sum_y[PW-1:FRAC];
        int_y_old = pos_y[PW-1:FRAC];
        vy_grav   = $signed({vy[7], vy}) + $signed(9'(GRAVITY));

        next_x   = sum_x[PW-1:0];
        next_vx  = vx;
        wall_hit = 1'b0;
        if (sum_x[PW] || int_x < XMIN_I) begin
            next_x   = {XMIN_I, {FRAC{1'b0}}};
            next_vx  = -vx;
            wall_hit = 1'b1;
        end else if (int_x > XMAX_I) begin
            next_x   = {XMAX_I, {FRAC{1'b0}}};
            next_vx  = -vx;
            wall_hit = 1'b1;
        end

        next_vy = (vy_grav > 9'sd127) ? 8'sd127 : vy_grav[7:0];
        next_y  = sum_y[PW] ? '0 : sum_y[PW-1:0];

        hoop_cross = !sum_y[PW] && !sum_x[PW] && (vy > 8'sd0)
                     && (int_y_old < HOOPY_I) && (int_y >= HOOPY_I)
                     && (int_x >= HOOPL_I) && (int_x <= HOOPR_I);

        floor_hit = !sum_y[PW] && (int_y >= FLOOR_I);
        if (floor_hit) begin
            next_y  = {FLOOR_I, {FRAC{1'b0}}};
            next_vx = '0;
            next_vy = '0;
        end
    end

endmodule

// File: rtl/ball_trajectory.sv
// Ball position writer: launches on shoot, integrates once per frame,
// rests on the floor for HOLD_FRAMES frames, then returns to the start point.
module ball_trajectory
    import ball_trajectory_pkg::*;
#(
    parameter int FRAC        = BT_FRAC,
    parameter int START_X     = 100,
    parameter int START_Y     = 400,
    parameter int GRAVITY     = 4,
    parameter int X_MIN       = 4,
    parameter int X_MAX       = 635,
    parameter int FLOOR_Y     = 475,
    parameter int HOOP_X_L    = 500,
    parameter int HOOP_X_R    = 530,
    parameter int HOOP_Y      = 200,
    parameter int HOLD_FRAMES = 60
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              refresh_tick,
    input  logic              shoot,
    input  logic signed [7:0] vx_in,
    input  logic signed [7:0] vy_in,
    output logic [9:0]        ball_x,
    output logic [9:0]        ball_y,
    output logic              in_flight,
    output logic              landed,
    output logic              scored
);

    localparam int PW = 10 + FRAC;
    localparam int HW = (HOLD_FRAMES > 2) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [PW-1:0] START_PX  = {10'(START_X), {FRAC{1'b0}}};
    localparam logic [PW-1:0] START_PY  = {10'(START_Y), {FRAC{1'b0}}};
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

    ball_state_t       state, state_n;
    logic [PW-1:0]     pos_x, pos_y, pos_x_n, pos_y_n;
    logic signed [7:0] vx, vy, vx_n, vy_n;
    logic [HW-1:0]     hold_cnt, hold_n;
    logic              scored_n;

    logic [PW-1:0]     step_x, step_y;
    logic signed [7:0] step_vx, step_vy;
    logic              wall_hit, floor_hit, hoop_cross;
    logic              wall_hit_unused;

    assign wall_hit_unused = wall_hit;

    ball_step #(
        .FRAC     (FRAC),
        .GRAVITY  (GRAVITY),
        .X_MIN    (X_MIN),
        .X_MAX    (X_MAX),
        .FLOOR_Y  (FLOOR_Y),
        .HOOP_X_L (HOOP_X_L),
        .HOOP_X_R (HOOP_X_R),
        .HOOP_Y   (HOOP_Y)
    ) u_step (
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .vx         (vx),
        .vy         (vy),
        .next_x     (step_x),
        .next_y     (step_y),
        .next_vx    (step_vx),
        .next_vy    (step_vy),
        .wall_hit   (wall_hit),
        .floor_hit  (floor_hit),
        .hoop_cross (hoop_cross)
    );

    always_comb begin
        state_n  = state;
        pos_x_n  = pos_x;
        pos_y_n  = pos_y;
        vx_n     = vx;
        vy_n     = vy;
        hold_n   = hold_cnt;
        scored_n = 1'b0;
        case (state)
            IDLE: begin
                // Launch only latches velocity; motion starts on the next tick.
                if (shoot) begin
                    state_n = FLIGHT;
                    vx_n    = vx_in;
                    vy_n    = vy_in;
                end
            end
            FLIGHT: begin
                if (refresh_tick) begin
                    pos_x_n  = step_x;
                    pos_y_n  = step_y;
                    vx_n     = step_vx;
                    vy_n     = step_vy;
                    scored_n = hoop_cross;
                    if (floor_hit) begin
                        state_n = LANDED;
                        hold_n  = '0;
                    end
                end
            end
            LANDED: begin
                if (refresh_tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_n = IDLE;
                        pos_x_n = START_PX;
                        pos_y_n = START_PY;
                        hold_n  = '0;
                    end else begin
                        hold_n = hold_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pos_x     <= START_PX;
            pos_y     <= START_PY;
            vx        <= '0;
            vy        <= '0;
            hold_cnt  <= '0;
            in_flight <= 1'b0;
            landed    <= 1'b0;
            scored    <= 1'b0;
        end else begin
            state     <= state_n;
            pos_x     <= pos_x_n;
            pos_y     <= pos_y_n;
            vx        <= vx_n;
            vy        <= vy_n;
            hold_cnt  <= hold_n;
            in_flight <= (state_n == FLIGHT);
            landed    <= (state_n == LANDED);
            scored    <= scored_n;
        end
    end

    assign ball_x = pos_x[PW-1:FRAC];
    assign ball_y = pos_y[PW-1:FRAC];

endmodule

// File: tb/tb_ball_trajectory.sv
// Directed bench: four parameterised instances cover launch, wall bounce, hoop score and floor hold.
module tb_ball_trajectory;
    import ball_trajectory_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [3:0]        tk = '0;
    logic [3:0]        sh = '0;
    logic signed [7:0] vx [4];
    logic signed [7:0] vy [4];
    logic [9:0]        bx [4];
    logic [9:0]        by [4];
    logic [3:0]        fl, ld, sc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ball_trajectory u_a (
        .clk(clk), .reset(reset), .refresh_tick(tk[0]), .shoot(sh[0]),
        .vx_in(vx[0]), .vy_in(vy[0]), .ball_x(bx[0]), .ball_y(by[0]),
        .in_flight(fl[0]), .landed(ld[0]), .scored(sc[0])
    );

    ball_trajectory #(.START_X(634)) u_w (
        .clk(clk), .reset(reset), .refresh_tick(tk[1]), .shoot(sh[1]),
        .vx_in(vx[1]), .vy_in(vy[1]), .ball_x(bx[1]), .ball_y(by[1]),
        .in_flight(fl[1]), .landed(ld[1]), .scored(sc[1])
    );

    ball_trajectory #(.START_X(510), .START_Y(190)) u_s (
        .clk(clk), .reset(reset), .refresh_tick(tk[2]), .shoot(sh[2]),
        .vx_in(vx[2]), .vy_in(vy[2]), .ball_x(bx[2]), .ball_y(by[2]),
        .in_flight(fl[2]), .landed(ld[2]), .scored(sc[2])
    );

    ball_trajectory #(.START_Y(470)) u_f (
        .clk(clk), .reset(reset), .refresh_tick(tk[3]), .shoot(sh[3]),
        .vx_in(vx[3]), .vy_in(vy[3]), .ball_x(bx[3]), .ball_y(by[3]),
        .in_flight(fl[3]), .landed(ld[3]), .scored(sc[3])
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int i);
        @(negedge clk);
        tk[i] = 1'b1;
        @(negedge clk);
        tk[i] = 1'b0;
    endtask

    task automatic fire(input int i, input logic signed [7:0] x, input logic signed [7:0] y);
        @(negedge clk);
        vx[i] = x;
        vy[i] = y;
        sh[i] = 1'b1;
        @(negedge clk);
        sh[i] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            vx[i] = '0;
            vy[i] = '0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check("rst_x", bx[0], 100);
        check("rst_y", by[0], 400);
        check("rst_flight", fl[0], 0);
        check("rst_landed", ld[0], 0);
        check("rst_scored", sc[0], 0);

        // Basic launch
        fire(0, 8'sd32, -8'sd64);
        check("launch_flight", fl[0], 1);
        check("launch_x_static", bx[0], 100);
        tick(0);
        check("t1_x", bx[0], 102);
        check("t1_y", by[0], 396);
        check("t1_vy", u_a.vy, -60);
        tick(0);
        check("t2_x", bx[0], 104);
        check("t2_y", by[0], 392);
        check("t2_flight", fl[0], 1);

        // Right wall bounce
        fire(1, 8'sd32, -8'sd16);
        tick(1);
        check("wall_x1", bx[1], 635);
        check("wall_vx", u_w.vx, -32);
        tick(1);
        check("wall_x2", bx[1], 633);

        // Hoop crossing: y 192,194,196,199,202 with the score on the fifth tick
        fire(2, 8'sd0, 8'sd32);
        tick(2);
        check("hoop_y1", by[2], 192);
        check("hoop_sc1", sc[2], 0);
        tick(2);
        check("hoop_y2", by[2], 194);
        tick(2);
        check("hoop_y3", by[2], 196);
        tick(2);
        check("hoop_y4", by[2], 199);
        check("hoop_sc4", sc[2], 0);
        tick(2);
        check("hoop_y5", by[2], 202);
        check("hoop_sc5", sc[2], 1);
        @(negedge clk);
        check("hoop_sc_pulse", sc[2], 0);

        // Floor landing and hold
        fire(3, 8'sd0, 8'sd64);
        tick(3);
        check("floor_y1", by[3], 474);
        check("floor_ld1", ld[3], 0);
        tick(3);
        check("floor_y2", by[3], 475);
        check("floor_ld2", ld[3], 1);
        check("floor_fl2", fl[3], 0);
        fire(3, 8'sd16, -8'sd64);
        check("landed_shoot_ld", ld[3], 1);
        check("landed_shoot_fl", fl[3], 0);
        repeat (59) tick(3);
        check("hold59_ld", ld[3], 1);
        check("hold59_y", by[3], 475);
        tick(3);
        check("hold60_ld", ld[3], 0);
        check("hold60_fl", fl[3], 0);
        check("hold60_x", bx[3], 100);
        check("hold60_y", by[3], 470);

        // Shoot coinciding with refresh_tick: no motion on the entering clk
        do_reset();
        @(negedge clk);
        vx[0] = 8'sd32;
        vy[0] = -8'sd64;
        sh[0] = 1'b1;
        tk[0] = 1'b1;
        @(negedge clk);
        sh[0] = 1'b0;
        tk[0] = 1'b0;
        check("same_fl", fl[0], 1);
        check("same_x", bx[0], 100);
        check("same_y", by[0], 400);
        repeat (3) @(negedge clk);
        check("same_static_y", by[0], 400);
        tick(0);
        check("same_t1_x", bx[0], 102);
        check("same_t1_y", by[0], 396);

        // Reset mid-flight at (120,360)
        do_reset();
        fire(0, 8'sd32, -8'sd82);
        repeat (10) tick(0);
        check("mid_x", bx[0], 120);
        check("mid_y", by[0], 360);
        do_reset();
        check("mid_rst_x", bx[0], 100);
        check("mid_rst_y", by[0], 400);
        check("mid_rst_fl", fl[0], 0);
        check("mid_rst_ld", ld[0], 0);
        check("mid_rst_sc", sc[0], 0);
        check("mid_rst_state", u_a.state, 0);
        tick(0);
        check("mid_rst_static", bx[0], 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ball_trajectory.md
Name: ball_trajectory

Overview:
- Produces the ball centre coordinates that the ball renderer consumes; it is the writer of the ball_x/ball_y interface.
- Integrates a launched shot once per video frame using fixed-point velocity and constant gravity.
- Bounces the ball off the side walls, detects a downward crossing of the hoop line, and parks the ball on the floor.
- Sits between the shot-input logic (angle/power to velocity) and the VGA object mux.

Parameters:
- FRAC, 4, fractional bits of position/velocity (1/16 px units)
- START_X, 100, idle/reset ball centre x (px)
- START_Y, 400, idle/reset ball centre y (px)
- GRAVITY, 4, vy increment per frame (1/16 px/frame²)
- X_MIN, 4, leftmost legal centre x
- X_MAX, 635, rightmost legal centre x
- FLOOR_Y, 475, floor centre y
- HOOP_X_L, 500, hoop left edge (px, inclusive)
- HOOP_X_R, 530, hoop right edge (px, inclusive)
- HOOP_Y, 200, rim line y (px)
- HOLD_FRAMES, 60, frames the ball rests in LANDED

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- refresh_tick  in  1  one-clk pulse per frame (start of vertical blank)
- shoot  in  1  launch request (level or pulse, sampled each clk)
- vx_in  in  8  signed launch x velocity, 1/16 px/frame
- vy_in  in  8  signed launch y velocity, 1/16 px/frame, negative = up
- ball_x  out  10  ball centre x, integer part of position
- ball_y  out  10  ball centre y, integer part of position
- in_flight  out  1  high in FLIGHT
- landed  out  1  high in LANDED
- scored  out  1  one-clk pulse on hoop crossing

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset values: state IDLE; position = (START_X, START_Y) << FRAC; vx = vy = 0; hold counter 0.
- Reset output values: ball_x = START_X, ball_y = START_Y, in_flight = 0, landed = 0, scored = 0.
- All outputs are registered. Reset mid-flight takes effect on the next clk edge, with no residual motion.
- Position regs are 10+FRAC bits unsigned; vx/vy regs are 8-bit signed.
- Next-position arithmetic is 15-bit signed, using a sign-extended velocity, so underflow is detectable.
- ball_x and ball_y are truncated integer parts of position.
- IDLE:
  - shoot=1 latches vx_in/vy_in and goes to FLIGHT.
  - No movement occurs on the entering clk, even if refresh_tick coincides with it.
- FLIGHT, on each refresh_tick (update visible 1 clk after the tick):
  - x' = x + vx and y' = y + vy, using the old vy.
  - vy' = vy + GRAVITY, saturating at +127.
  - If int(x') < X_MIN: x = X_MIN, vx = -vx.
  - If int(x') > X_MAX: x = X_MAX, vx = -vx.
  - If y' < 0: clamp y to 0, keep vy.
  - If int(y') >= FLOOR_Y: y = FLOOR_Y with frac 0, vx = vy = 0, go to LANDED, clear the hold counter.
  - scored pulses for exactly 1 clk when all hold: int(y) < HOOP_Y, int(y') >= HOOP_Y, vy > 0, HOOP_X_L <= int(x') <= HOOP_X_R.
  - Floor and score in the same tick: both take effect.
  - shoot is ignored.
- LANDED:
  - The hold counter increments on each refresh_tick.
  - When the count reaches HOLD_FRAMES-1 on a tick: go to IDLE and reload the start position.
  - shoot is ignored.
- Without refresh_tick, state and position are static. Multiple shoot clks in IDLE: the first one wins.

Decomposition:
- Shared package: screen limits (640x480), FRAC, ball radius 4, and the state enum {IDLE, FLIGHT, LANDED}. The renderer shares these.
- One combinational sub-module, ball_step. Inputs: position and velocity. Outputs: next position, next velocity, wall_hit, floor_hit, hoop_cross.
- The top module holds the FSM, registers and hold counter.

Test Plan:
- Defaults; reset; shoot with vx=+32, vy=-64; two ticks:
  - After tick 1: ball=(102,396), vy=-60.
  - After tick 2: ball=(104,392), in_flight=1.
- Shoot asserted in the same clk as refresh_tick -> state FLIGHT, ball stays (100,400) until the next tick.
- Wall bounce: START_X=634, vx=+32, vy=-16 -> after tick 1: ball_x=635, vx=-32; after tick 2: ball_x=633.
- Score: START_X=510, START_Y=190, vx=0, vy=+32:
  - ball_y sequence 192, 194, 196, 199, 202.
  - scored pulses 1 clk after tick 5 only.
- Floor: START_Y=470, vy=+64:
  - Tick 1: ball_y=474.
  - Tick 2: ball_y=475, landed=1, in_flight=0.
  - Shoot ignored while landed.
  - After 60 ticks: IDLE, ball=(100,470).
- Reset asserted mid-flight at ball=(120,360) -> next clk: IDLE, ball=(100,400), all flags 0.
